// File: rtl/sfa_valu_pkg.sv
// Shared types and constants for the sfa_valu streaming vector ALU.
// Saturating ADD/SUB is selected at build time with SFA_VALU_SAT_EN.
package sfa_valu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5
    } opcode_e;

    localparam logic [7:0] ST_OK         = 8'h00;
    localparam logic [7:0] ST_BAD_OPCODE = 8'h01;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StStream,
        StDrain,
        StResp
    } state_e;

    // Command word layout
    localparam int unsigned CmdOpLsb  = 0;
    localparam int unsigned CmdOpW    = 4;
    localparam int unsigned CmdLenLsb = 16;

    function automatic logic isLegalOp(input logic [3:0] op);
        return (op >= 4'(OP_ADD)) && (op <= 4'(OP_XOR));
    endfunction

endpackage

// File: rtl/sfa_valu_alu.sv
// Combinational element operation for sfa_valu.
// SFA_VALU_SAT_EN: ADD/SUB clamp to the signed DATA_W range instead of wrapping.
module sfa_valu_alu
    import sfa_valu_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        opcode,
    output logic [DATA_W-1:0] result
);

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic [DATA_W-1:0] addRes;
    logic [DATA_W-1:0] subRes;

    assign sum  = a + b;
    assign diff = a - b;

`ifdef SFA_VALU_SAT_EN
    localparam logic [DATA_W-1:0] SatMax = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SatMin = {1'b1, {(DATA_W-1){1'b0}}};

    logic addOvf;
    logic subOvf;

    // Signed overflow: result sign disagrees with the sign the operands imply
    assign addOvf = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
    assign subOvf = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
    assign addRes = addOvf ? (a[DATA_W-1] ? SatMin : SatMax) : sum;
    assign subRes = subOvf ? (a[DATA_W-1] ? SatMin : SatMax) : diff;
`else
    assign addRes = sum;
    assign subRes = diff;
`endif

    always_comb begin
        result = '0;
        case (opcode)
            OP_ADD:  result = addRes;
            OP_SUB:  result = subRes;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/sfa_valu.sv
// Streaming vector ALU: command in, joined operand streams through sfa_valu_alu, status out.
// Build option SFA_VALU_SAT_EN enables saturating ADD/SUB inside the ALU.
module sfa_valu
    import sfa_valu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              ACLK,
    input  logic              ARESET,
    output logic              sCMD_tready,
    input  logic              sCMD_tvalid,
    input  logic [31:0]       sCMD_tdata,
    input  logic              mRet_tready,
    output logic              mRet_tvalid,
    output logic [31:0]       mRet_tdata,
    output logic              sIn1_tready,
    input  logic              sIn1_tvalid,
    input  logic [DATA_W-1:0] sIn1_tdata,
    output logic              sIn2_tready,
    input  logic              sIn2_tvalid,
    input  logic [DATA_W-1:0] sIn2_tdata,
    input  logic              mOut_tready,
    output logic              mOut_tvalid,
    output logic [DATA_W-1:0] mOut_tdata
);

    state_e            stateQ, stateD;
    logic              cmdReadyQ;
    logic [3:0]        opcodeQ;
    logic [LEN_W-1:0]  lenQ;
    logic [LEN_W-1:0]  countQ;
    logic [7:0]        statusQ;
    logic              outValidQ;
    logic [DATA_W-1:0] outDataQ;
    logic [DATA_W-1:0] aluResult;
    logic              cmdFire;
    logic              slotFree;
    logic              opFire;
    logic              lastFire;
    logic              unusedCmdBits;

    assign unusedCmdBits = ^sCMD_tdata;

    // Registered ready keeps sCMD_tready low for the first cycle out of reset
    assign sCMD_tready = cmdReadyQ;
    assign cmdFire     = sCMD_tvalid && cmdReadyQ;
    assign opFire      = sIn1_tvalid && sIn1_tready;
    assign lastFire    = opFire && (countQ == lenQ - LEN_W'(1));
    assign mOut_tvalid = outValidQ;
    assign mOut_tdata  = outDataQ;
    assign mRet_tdata  = {16'(countQ), 8'h00, statusQ};

    sfa_valu_alu #(
        .DATA_W(DATA_W)
    ) uAlu (
        .a     (sIn1_tdata),
        .b     (sIn2_tdata),
        .opcode(opcodeQ),
        .result(aluResult)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            stateQ <= StFetch;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StFetch:  if (cmdFire) stateD = StDecode;
            StDecode: begin
                if (!isLegalOp(opcodeQ) || (lenQ == '0)) begin
                    stateD = StResp;
                end else begin
                    stateD = StStream;
                end
            end
            StStream: if (lastFire) stateD = StDrain;
            StDrain:  if (!outValidQ || mOut_tready) stateD = StResp;
            StResp:   if (mRet_tready) stateD = StFetch;
            default:  stateD = StFetch;
        endcase
    end

    always_comb begin
        sIn1_tready = 1'b0;
        sIn2_tready = 1'b0;
        slotFree    = !outValidQ || mOut_tready;
        // Each side's ready waits on the other's valid so the join is all-or-nothing
        if ((stateQ == StStream) && (countQ < lenQ)) begin
            sIn1_tready = sIn2_tvalid && slotFree;
            sIn2_tready = sIn1_tvalid && slotFree;
        end
        mRet_tvalid = (stateQ == StResp);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cmdReadyQ <= 1'b0;
            opcodeQ   <= '0;
            lenQ      <= '0;
            countQ    <= '0;
            statusQ   <= ST_OK;
            outValidQ <= 1'b0;
            outDataQ  <= '0;
        end else begin
            cmdReadyQ <= (stateD == StFetch);
            if (cmdFire) begin
                opcodeQ <= sCMD_tdata[CmdOpLsb +: CmdOpW];
                lenQ    <= sCMD_tdata[CmdLenLsb +: LEN_W];
                countQ  <= '0;
                statusQ <= ST_OK;
            end
            if ((stateQ == StDecode) && !isLegalOp(opcodeQ)) begin
                statusQ <= ST_BAD_OPCODE;
            end
            if (opFire) begin
                outValidQ <= 1'b1;
                outDataQ  <= aluResult;
                countQ    <= countQ + LEN_W'(1);
            end else if (mOut_tready) begin
                outValidQ <= 1'b0;
            end
        end
    end

endmodule

// File: doc/sfa_valu.md
# sfa_valu

Parametrised streaming vector ALU, the successor of the single-operation vector adder in the SFA accelerator fabric. It accepts a command word on the command stream, then joins two operand streams element by element. It applies the commanded operation, with one result per cycle at full throughput, and emits a status/count word on the return stream. The vector length comes from the command, not from a fixed port.

## Interface
- DATA_W, 32, operand/result width (8..64)
- LEN_W, 16, element-count width (≤16)
- ACLK  in  1  clock, all logic on rising edge
- ARESET  in  1  synchronous, active-high reset
- sCMD_tready  out  1  command accept
- sCMD_tvalid  in  1  command valid
- sCMD_tdata  in  32  [3:0] opcode, [15:4] reserved, [31:16] length (low LEN_W bits used)
- mRet_tready  in  1  return accept
- mRet_tvalid  out  1  return valid
- mRet_tdata  out  32  [31:16] elements processed, [15:8] 0, [7:0] status
- sIn1_tready / sIn2_tready  out  1  operand accept
- sIn1_tvalid / sIn2_tvalid  in  1  operand valid
- sIn1_tdata / sIn2_tdata  in  DATA_W  operands A / B
- mOut_tready  in  1  result accept
- mOut_tvalid  out  1  result valid
- mOut_tdata  out  DATA_W  result

## Operation
- Opcodes: 1 ADD (A+B), 2 SUB (A−B), 3 AND, 4 OR, 5 XOR. All other values are illegal.
- Status values: 0x00 OK, 0x01 BAD_OPCODE.
- FSM states: FETCH, DECODE, STREAM, DRAIN, RESP.
  - FETCH: sCMD_tready=1. On tvalid, latch opcode and length, clear count, go to DECODE.
  - DECODE (1 cycle): illegal opcode → RESP with status 0x01 and count 0. Length 0 → RESP with status 0x00 and count 0. Otherwise → STREAM.
  - STREAM: operand join. Fire = sIn1_tvalid & sIn2_tvalid & (!mOut_tvalid | mOut_tready) & count<length.
    - sIn1_tready = sIn2_tvalid & slot_free; sIn2_tready = sIn1_tvalid & slot_free. One side is never consumed alone.
    - On fire: result register loads op(A,B), mOut_tvalid=1, count+1.
    - After the last operand fires → DRAIN.
  - DRAIN: hold until the result register is empty (mOut_tvalid=0, or handshake completes this cycle) → RESP.
  - RESP: mRet_tvalid=1, data {count, 8'h00, status}. Hold until mRet_tready → FETCH.
- Arithmetic wraps modulo 2^DATA_W unless the saturation feature is compiled in. Logic ops are bitwise.
- Commands are never accepted outside FETCH. Operands are never accepted outside STREAM.

## Timing
- Reset values: every tready=0, every tvalid=0, every tdata=0. FSM in FETCH. sCMD_tready rises the first cycle after ARESET deasserts.
- Command handshake to first possible operand accept: 2 cycles (FETCH→DECODE→STREAM).
- Operand fire to mOut_tvalid: 1 cycle. Sustained throughput is 1 element/cycle with mOut_tready held high.
- Backpressure: a result is held stable while mOut_tvalid & !mOut_tready. New operands are accepted in the same cycle the held result drains.
- Last result handshake to mRet_tvalid: 1 cycle.
- Length = 2^LEN_W−1 must complete without count overflow.
- Reset asserted mid-vector discards everything in flight. Outputs take reset values on the next edge.

## Configuration
- SFA_VALU_SAT_EN defined: ADD and SUB saturate, treating operands as signed two's complement, clamped to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- SFA_VALU_SAT_EN undefined: ADD and SUB wrap. Logic ops are identical in both builds.

## Structure
- Package sfa_valu_pkg holds:
  - opcode enum (OP_ADD..OP_XOR)
  - status constants (ST_OK, ST_BAD_OPCODE)
  - FSM state enum
  - command-field bit positions
- Sub-module sfa_valu_alu: combinational op(A,B,opcode), DATA_W-parametrised, containing the saturation logic under SFA_VALU_SAT_EN.
- The top level holds the FSM, counter, join logic and result/return registers.

## Test plan
- ADD, length 4, A={1,2,3,0xFFFFFFFF}, B={10,20,30,1}, mOut_tready high → out {11,22,33,0} back-to-back; ret 0x00040000.
- SUB, length 3, random mOut_tready and independently random operand valids → results A−B in order, no loss or duplication, each operand consumed exactly once; ret count 3.
- Opcode 9, length 5 → no operand accepted; ret 0x00000001.
- ADD, length 0 → ret 0x00000000 two cycles after command accept, no mOut_tvalid.
- With SFA_VALU_SAT_EN, ADD 0x7FFFFFFF+1 → 0x7FFFFFFF; SUB 0x80000000−1 → 0x80000000. Without it → 0x80000000 and 0x7FFFFFFF.
- ARESET pulsed after 2 of 8 elements → all valids 0 next cycle; a new ADD length 1 command then completes normally.
